// File: rtl/fp32_to_int_conv.sv
// Iterative FP32 -> signed integer converter with valid/ready handshakes and saturation.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp32_to_int_conv #(
  parameter int INT_W         = 32,
  parameter int SHIFT_PER_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nan,
  output logic             out_inexact
);

  // One spare bit above the integer range so a rounding carry stays visible to the overflow check.
  localparam int MAG_W = ((INT_W > 24) ? INT_W : 24) + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [4:0]       STEP    = 5'(SHIFT_PER_CYC);
  localparam logic [7:0]       EXP_TOP = 8'(127 + INT_W - 1);
  localparam logic [MAG_W-1:0] MAG_ONE = {{(MAG_W-1){1'b0}}, 1'b1};
  localparam logic [MAG_W-1:0] LIM_NEG = MAG_ONE << (INT_W - 1);
  localparam logic [MAG_W-1:0] LIM_POS = LIM_NEG - MAG_ONE;
  localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W-1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [31:0]      op_q, op_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             valid_q, valid_d;
  logic [INT_W-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             nan_q, nan_d;
  logic             inx_q, inx_d;

  logic             sign;
  logic [7:0]       exp_f;
  logic [22:0]      frac;
  logic [4:0]       amt;
  logic [MAG_W-1:0] mask;
  logic [MAG_W-1:0] low;
  logic             inc;
  logic [MAG_W-1:0] mag_rnd;
  logic [INT_W-1:0] mag_int;
  logic [INT_W-1:0] res_signed;
  logic             rnd_ovf;
  logic [INT_W-1:0] sat_val;

  assign sign    = op_q[31];
  assign exp_f   = op_q[30:23];
  assign frac    = op_q[22:0];
  assign sat_val = sign ? SAT_NEG : SAT_POS;

  assign amt  = (cnt_q < STEP) ? cnt_q : STEP;
  assign mask = (MAG_ONE << amt) - MAG_ONE;
  assign low  = mag_q & mask;

`ifdef FP2INT_ROUND_NEAREST_EN
  assign inc = guard_q & (sticky_q | mag_q[0]);
`else
  assign inc = 1'b0;
`endif

  assign mag_rnd    = mag_q + {{(MAG_W-1){1'b0}}, inc};
  assign rnd_ovf    = sign ? (mag_rnd > LIM_NEG) : (mag_rnd > LIM_POS);
  assign mag_int    = mag_rnd[INT_W-1:0];
  assign res_signed = sign ? ({INT_W{1'b0}} - mag_int) : mag_int;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    nan_d    = nan_q;
    inx_d    = inx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        data_d   = '0;
        ovf_d    = 1'b0;
        nan_d    = 1'b0;
        inx_d    = 1'b0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        left_d   = 1'b0;
        cnt_d    = '0;
        mag_d    = {{(MAG_W-24){1'b0}}, 1'b1, frac};
        state_d  = ST_DONE;
        if (exp_f == 8'hFF) begin
          if (frac != 23'd0) begin
            nan_d = 1'b1;
          end else begin
            data_d = sat_val;
            ovf_d  = 1'b1;
          end
        end else if (exp_f >= EXP_TOP) begin
          // -2^(INT_W-1) is the one value at this exponent that fits exactly.
          data_d = sat_val;
          ovf_d  = !(sign && (exp_f == EXP_TOP) && (frac == 23'd0));
        end else if (exp_f == 8'd0) begin
          inx_d = |frac;
        end else if (exp_f < 8'd127) begin
          mag_d    = '0;
          guard_d  = (exp_f == 8'd126);
          sticky_d = (exp_f == 8'd126) ? |frac : 1'b1;
          state_d  = ST_ROUND;
        end else if (exp_f > 8'd150) begin
          left_d  = 1'b1;
          cnt_d   = exp_f[4:0] - 5'd22;
          state_d = ST_SHIFT;
        end else if (exp_f < 8'd150) begin
          cnt_d   = 5'd22 - exp_f[4:0];
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << amt;
        end else begin
          mag_d    = mag_q >> amt;
          guard_d  = |(low & ~(mask >> 1));
          sticky_d = sticky_q | guard_q | (|(low & (mask >> 1)));
        end
        cnt_d = cnt_q - amt;
        if (cnt_q == amt) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        ovf_d   = rnd_ovf;
        inx_d   = (guard_q | sticky_q) & ~rnd_ovf;
        data_d  = rnd_ovf ? sat_val : res_signed;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // out_valid rises one cycle after the result is loaded.
        valid_d = 1'b1;
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      mag_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      nan_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      nan_q    <= nan_d;
      inx_q    <= inx_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_ovf     = ovf_q;
  assign out_nan     = nan_q;
  assign out_inexact = inx_q;

endmodule
